// File: rtl/row_deserializer.sv
// row_deserializer
//   Collects a serial bit stream (MSB of each row first) into WIDTH-bit rows
//   and presents each completed row on a valid/ready output buffer. A second
//   completed row can wait in the shift register while the buffer is still
//   occupied. Strobes that arrive while both are full are dropped and flagged.
//
// Ports
//   clock      in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset (release synchronized inside)
//   serial_in  in   serial pixel bit, sampled when shift=1
//   shift      in   bit strobe
//   clear      in   synchronous abort of the partial or held row
//   row_data   out  last completed row, first-received bit at [WIDTH-1]
//   row_valid  out  row_data holds an unconsumed row
//   row_ready  in   consumer accepts row_data while row_valid=1
//   bit_count  out  bits collected in the current row
//   stall      out  a completed row is held internally
//   overflow   out  sticky: a shift strobe was dropped
module row_deserializer #(
    parameter int WIDTH = 128
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     serial_in,
    input  logic                     shift,
    input  logic                     clear,
    output logic [WIDTH-1:0]         row_data,
    output logic                     row_valid,
    input  logic                     row_ready,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     stall,
    output logic                     overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    // Assertion follows reset_n immediately; release is delayed two edges so
    // that no state flop sees reset removed near its active edge.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   row_data_q, row_data_d;
    logic               row_valid_q, row_valid_d;
    logic               overflow_q, overflow_d;

    logic [WIDTH-1:0]   sr_shifted;
    logic               buf_free;

    assign sr_shifted = {sr_q[WIDTH-2:0], serial_in};
    // The output buffer can take a row this edge if empty or being consumed.
    assign buf_free   = !row_valid_q || row_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        row_data_d  = row_data_q;
        // Handshake consumes the current row unless a new one is loaded below.
        row_valid_d = row_valid_q && !row_ready;
        overflow_d  = overflow_q;

        if (clear) begin
            state_d    = COLLECT;
            cnt_d      = '0;
            overflow_d = 1'b0;
        end else if (state_q == COLLECT) begin
            if (shift) begin
                sr_d = sr_shifted;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (buf_free) begin
                        row_data_d  = sr_shifted;
                        row_valid_d = 1'b1;
                    end else begin
                        // Completed row stays in sr until the buffer frees up.
                        state_d = FULL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end else begin
            if (buf_free) begin
                row_data_d  = sr_q;
                row_valid_d = 1'b1;
                state_d     = COLLECT;
                if (shift) begin
                    // The held row has just left sr, so this bit starts a new row.
                    sr_d  = sr_shifted;
                    cnt_d = CNT_ONE;
                end
            end else if (shift) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            sr_q        <= '0;
            row_data_q  <= '0;
            row_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            row_data_q  <= row_data_d;
            row_valid_q <= row_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign row_data  = row_data_q;
    assign row_valid = row_valid_q;
    assign bit_count = cnt_q;
    assign stall     = (state_q == FULL);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_row_deserializer.sv
// tb_row_deserializer
//   Directed scenarios followed by a randomized run, each cycle compared
//   against a queue-based model of rows, held row and output buffer.
module tb_row_deserializer;

    localparam int W = 128;

    logic         clock;
    logic         reset_n;
    logic         serial_in;
    logic         shift;
    logic         clear;
    logic [W-1:0] row_data;
    logic         row_valid;
    logic         row_ready;
    logic [6:0]   bit_count;
    logic         stall;
    logic         overflow;

    row_deserializer #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .serial_in (serial_in),
        .shift     (shift),
        .clear     (clear),
        .row_data  (row_data),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .bit_count (bit_count),
        .stall     (stall),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state.
    logic [W-1:0] m_data;
    bit           m_valid;
    bit           m_bits[$];
    logic [W-1:0] m_held;
    bit           m_has_held;
    bit           m_ov;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data     = '0;
        m_valid    = 1'b0;
        m_bits.delete();
        m_held     = '0;
        m_has_held = 1'b0;
        m_ov       = 1'b0;
    endtask

    function automatic logic [W-1:0] pack_bits();
        logic [W-1:0] r;
        r = '0;
        foreach (m_bits[i]) r = {r[W-2:0], m_bits[i]};
        return r;
    endfunction

    task automatic model_step();
        bit           space;
        logic [W-1:0] row;
        space = !m_valid || row_ready;
        if (clear) begin
            m_bits.delete();
            m_has_held = 1'b0;
            m_ov       = 1'b0;
            if (m_valid && row_ready) m_valid = 1'b0;
        end else if (m_has_held) begin
            if (space) begin
                m_data     = m_held;
                m_valid    = 1'b1;
                m_has_held = 1'b0;
                if (shift) m_bits.push_back(serial_in);
            end else if (shift) begin
                m_ov = 1'b1;
            end
        end else begin
            if (m_valid && row_ready) m_valid = 1'b0;
            if (shift) begin
                m_bits.push_back(serial_in);
                if (m_bits.size() == W) begin
                    row = pack_bits();
                    m_bits.delete();
                    if (space) begin
                        m_data  = row;
                        m_valid = 1'b1;
                    end else begin
                        m_held     = row;
                        m_has_held = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".row_data"},  row_data, m_data);
        chk({tag, ".row_valid"}, W'(row_valid), W'(m_valid));
        chk({tag, ".bit_count"}, W'(bit_count), W'(m_bits.size()));
        chk({tag, ".stall"},     W'(stall), W'(m_has_held));
        chk({tag, ".overflow"},  W'(overflow), W'(m_ov));
    endtask

    // Apply one cycle of inputs, advance model at the edge, compare 1 ns later.
    task automatic drive(input bit sh, input bit sin, input bit rdy, input bit clr, input string tag);
        shift     = sh;
        serial_in = sin;
        row_ready = rdy;
        clear     = clr;
        @(posedge clock);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic send_row(input logic [W-1:0] v, input bit rdy, input string tag);
        for (int i = 0; i < W; i++) drive(1'b1, v[W-1-i], rdy, 1'b0, tag);
    endtask

    // Assert reset mid-cycle, confirm outputs drop without a clock edge.
    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        chk({tag, ".async_data"},  row_data, '0);
        chk({tag, ".async_valid"}, W'(row_valid), '0);
        chk({tag, ".async_cnt"},   W'(bit_count), '0);
        chk({tag, ".async_stall"}, W'(stall), '0);
        chk({tag, ".async_ov"},    W'(overflow), '0);
        model_reset();
        shift = 1'b0; clear = 1'b0; row_ready = 1'b0; serial_in = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, {tag, ".release"});
    endtask

    logic [W-1:0] pat, loop_val, shifter, row_a, row_b, row_c, row_x;

    initial begin
        reset_n   = 1'b0;
        shift     = 1'b0;
        serial_in = 1'b0;
        clear     = 1'b0;
        row_ready = 1'b0;
        model_reset();
        #1;
        chk("reset.row_data",  row_data, '0);
        chk("reset.row_valid", W'(row_valid), '0);
        chk("reset.stall",     W'(stall), '0);
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, "release");

        // Single row with the end bits set.
        pat = {1'b1, 126'd0, 1'b1};
        send_row(pat, 1'b1, "corner");
        chk("corner.valid_const", W'(row_valid), W'(1));
        chk("corner.data_const",  row_data, {1'b1, 126'd0, 1'b1});
        chk("corner.cnt_const",   W'(bit_count), '0);

        // Loopback from a parallel-load shifter emitting its MSB first.
        loop_val = 128'hDEADBEEF_01234567_89ABCDEF_1234CAFE;
        shifter  = loop_val;
        for (int i = 0; i < W; i++) begin
            drive(1'b1, shifter[W-1], 1'b1, 1'b0, "loop");
            shifter = {shifter[W-2:0], 1'b0};
        end
        chk("loop.data_const", row_data, 128'hDEADBEEF_01234567_89ABCDEF_1234CAFE);

        // Backpressure: A in buffer, B held, extra strobe dropped.
        drive(1'b0, 1'b0, 1'b1, 1'b0, "bp.drain");
        row_a = {$urandom, $urandom, $urandom, $urandom};
        row_b = {$urandom, $urandom, $urandom, $urandom};
        send_row(row_a, 1'b0, "bp.a");
        send_row(row_b, 1'b0, "bp.b");
        drive(1'b0, 1'b0, 1'b0, 1'b0, "bp.hold");
        chk("bp.data_is_a", row_data, row_a);
        chk("bp.stall_set", W'(stall), W'(1));
        drive(1'b1, 1'b1, 1'b0, 1'b0, "bp.extra");
        chk("bp.overflow_set", W'(overflow), W'(1));
        drive(1'b0, 1'b0, 1'b1, 1'b0, "bp.release");
        chk("bp.data_is_b", row_data, row_b);
        chk("bp.stall_clr", W'(stall), '0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, "bp.clear_ov");
        chk("bp.ov_cleared", W'(overflow), '0);

        // Continuous back-to-back rows with the consumer always ready.
        row_a = {$urandom, $urandom, $urandom, $urandom};
        row_b = {$urandom, $urandom, $urandom, $urandom};
        row_c = {$urandom, $urandom, $urandom, $urandom};
        send_row(row_a, 1'b1, "cont.a");
        chk("cont.a_data", row_data, row_a);
        send_row(row_b, 1'b1, "cont.b");
        chk("cont.b_data", row_data, row_b);
        send_row(row_c, 1'b1, "cont.c");
        chk("cont.c_data", row_data, row_c);
        chk("cont.no_ov",  W'(overflow), '0);

        // Abort a partial row with clear.
        for (int i = 0; i < 50; i++) drive(1'b1, 1'($urandom), 1'b1, 1'b0, "clr.partial");
        drive(1'b1, 1'b1, 1'b1, 1'b1, "clr.pulse");
        chk("clr.cnt_zero", W'(bit_count), '0);
        row_x = {$urandom, $urandom, $urandom, $urandom};
        send_row(row_x, 1'b1, "clr.x");
        chk("clr.x_data", row_data, row_x);

        // Reset in the middle of a row.
        for (int i = 0; i < 77; i++) drive(1'b1, 1'($urandom), 1'b1, 1'b0, "rst.mid");
        async_reset("rst.mid");
        row_x = {$urandom, $urandom, $urandom, $urandom};
        send_row(row_x, 1'b1, "rst.mid_row");
        chk("rst.mid_data", row_data, row_x);

        // Reset while a row is held.
        send_row({$urandom, $urandom, $urandom, $urandom}, 1'b0, "rst.full_a");
        send_row({$urandom, $urandom, $urandom, $urandom}, 1'b0, "rst.full_b");
        chk("rst.full_stall", W'(stall), W'(1));
        async_reset("rst.full");
        row_x = {$urandom, $urandom, $urandom, $urandom};
        send_row(row_x, 1'b1, "rst.full_row");
        chk("rst.full_data", row_data, row_x);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
